// File: rtl/fp_div_seq_if.sv
// rtl/fp_div_seq_if.sv - start/busy/done handshake, operands, quotient and flags of fp_div_seq
//
// Signals:
//   start                    request, sampled by the divider only while idle
//   a, b                     dividend and divisor (W = 1+EXP_W+MAN_W bits)
//   result                   quotient, held until the next accepted start
//   busy, done               busy outside IDLE; done is a one-cycle result-valid pulse
//   div_by_zero, invalid,
//   overflow, underflow      exception flags, valid with done and held afterwards
// Modports: master (requester side), slave (divider side).
interface fp_div_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         invalid;
    logic         overflow;
    logic         underflow;

    modport master (
        output start, a, b,
        input  result, busy, done, div_by_zero, invalid, overflow, underflow
    );

    modport slave (
        input  start, a, b,
        output result, busy, done, div_by_zero, invalid, overflow, underflow
    );
endinterface

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - multi-cycle IEEE-754 divider, restoring mantissa divide, RNE, flush-to-zero
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any operation in flight
//   bus   fp_div_seq_if.slave: start/a/b in; result/busy/done and the
//         div_by_zero/invalid/overflow/underflow flags out
// Normal operands finish MAN_W+5 edges after the start-sampling edge,
// special operands after 2.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst,
    fp_div_seq_if.slave  bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int QW   = MAN_W + 3;            // quotient bits: integer, MAN_W fraction, guard, extra
    localparam int RW   = MAN_W + 2;            // remainder stays below 2*den
    localparam int XW   = EXP_W + 2;            // signed working exponent
    localparam int CW   = $clog2(MAN_W + 4);

    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            a_q, a_d, b_q, b_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [MAN_W:0]          den_q, den_d;
    logic [QW-1:0]           q_q, q_d;
    logic signed [XW-1:0]    exp_q, exp_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sign_q, sign_d;
    logic [W-1:0]            result_q, result_d;
    logic                    dz_q, dz_d, inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d;

    // operand fields
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        fa, fb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    // one restoring-division step, shared by PREP (first bit) and DIV
    logic [RW-1:0]           step_in, step_sub, step_next;
    logic [MAN_W:0]          step_den;
    logic                    step_ge;

    // normalise/round
    logic                    norm_hi, norm_guard, norm_sticky, norm_inc;
    logic [MAN_W-1:0]        norm_frac;
    logic [MAN_W:0]          norm_rnd;
    logic signed [XW-1:0]    norm_exp;

    assign ea = a_q[W-2 -: EXP_W];
    assign eb = b_q[W-2 -: EXP_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];

    // exponent 0 covers denormals too, so they are flushed to zero here
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    always_comb begin
        // PREP produces the first quotient bit directly from the hidden-bit
        // mantissas so that DIV needs only MAN_W+2 further cycles.
        step_in   = (state_q == S_PREP) ? {2'b01, fa} : rem_q;
        step_den  = (state_q == S_PREP) ? {1'b1, fb}  : den_q;
        step_ge   = (step_in >= {1'b0, step_den});
        step_sub  = step_ge ? (step_in - {1'b0, step_den}) : step_in;
        step_next = step_sub << 1;

        // quotient lies in (0.5, 2): either bit QW-1 or QW-2 is the leading one
        norm_hi     = q_q[QW-1];
        norm_frac   = norm_hi ? q_q[MAN_W+1:2] : q_q[MAN_W:1];
        norm_guard  = norm_hi ? q_q[1] : q_q[0];
        norm_sticky = (norm_hi & q_q[0]) | (rem_q != '0);
        norm_inc    = norm_guard & (norm_sticky | norm_frac[0]);
        norm_rnd    = {1'b0, norm_frac} + {{MAN_W{1'b0}}, norm_inc};
        // a fraction carry-out leaves norm_rnd[MAN_W-1:0] all zero, which is
        // exactly the mantissa of the next binade
        norm_exp    = exp_q
                    - $signed({{(XW-1){1'b0}}, ~norm_hi})
                    + $signed({{(XW-1){1'b0}}, norm_rnd[MAN_W]});

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        den_d    = den_q;
        q_d      = q_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;
        dz_d     = dz_q;
        inv_d    = inv_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    dz_d    = 1'b0;
                    inv_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sign_d  = a_q[W-1] ^ b_q[W-1];
                state_d = S_DONE;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                    inv_d    = 1'b1;
                end else if (a_inf) begin
                    result_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (b_inf) begin
                    result_d = {sign_d, {(W-1){1'b0}}};
                end else if (b_zero) begin
                    result_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    dz_d     = 1'b1;
                end else if (a_zero) begin
                    result_d = {sign_d, {(W-1){1'b0}}};
                end else begin
                    den_d   = {1'b1, fb};
                    exp_d   = XW'(ea) - XW'(eb) + XW'(BIAS);
                    q_d     = {step_ge, {(QW-1){1'b0}}};
                    rem_d   = step_next;
                    cnt_d   = CW'(1);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                q_d   = q_q | ({{(QW-1){1'b0}}, step_ge} << (CW'(QW - 1) - cnt_q));
                rem_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MAN_W + 2)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                state_d = S_DONE;
                if (norm_exp >= EXP_MAX) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d    = 1'b1;
                end else if (norm_exp[XW-1] || (norm_exp == '0)) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, norm_exp[EXP_W-1:0], norm_rnd[MAN_W-1:0]};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            den_q    <= '0;
            q_q      <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
            inv_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            den_q    <= den_d;
            q_q      <= q_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            inv_q    <= inv_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = dz_q;
    assign bus.invalid     = inv_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule
